// File: rtl/uart_pkg.sv
// Shared types for the UART bridge: FSM state encodings and the bit-counter width.
package uart_pkg;

    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead head; pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_serial_bridge.sv
// Processor serial port to 8N1 UART bridge: TX FIFO + serialiser, synchronised deserialiser + RX FIFO.
//   state        | meaning
//   TX_IDLE      | line high, waiting for a byte in the TX FIFO
//   TX_START     | driving the start bit (low)
//   TX_DATA      | shifting out 8 data bits, LSB first
//   TX_STOP      | driving the stop bit; chains straight into the next frame if one is queued
//   RX_IDLE      | waiting for a low level on the synchronised line
//   RX_START     | timing to the start-bit centre to reject glitches
//   RX_DATA      | sampling 8 data bits at their centres
//   RX_STOP      | sampling the stop bit, then push / overrun / framing error
//   RX_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_serial_bridge
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       rx_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);

    localparam int                CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    tx_state_t              tx_state, tx_state_d;
    logic [CW-1:0]          tx_cnt, tx_cnt_d;
    logic [BIT_CNT_W-1:0]   tx_bit, tx_bit_d;
    logic [7:0]             tx_shift, tx_shift_d;
    logic                   tx_line, tx_line_d;
    logic                   tx_pop;
    logic [7:0]             tx_head;
    logic                   tx_full, tx_empty;

    rx_state_t              rx_state, rx_state_d;
    logic [CW-1:0]          rx_cnt, rx_cnt_d;
    logic [BIT_CNT_W-1:0]   rx_bit, rx_bit_d;
    logic [7:0]             rx_shift, rx_shift_d;
    logic                   rx_meta, rx_sync;
    logic                   rx_push, set_overrun, set_frame_err;
    logic                   rx_full, rx_empty;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (tx_wren_in),
        .pop     (tx_pop),
        .wr_data (tx_data_in),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (rx_push),
        .pop     (rx_rden_in),
        .wr_data (rx_shift),
        .rd_data (rx_data_out),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign tx_ready_out = !tx_full;
    assign rx_valid_out = !rx_empty;
    assign uart_tx_out  = tx_line;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_line  <= tx_line_d;
        end
    end

    // The line value is computed one cycle ahead so the output is a flop.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_line_d  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = BIT_LAST;
                    tx_line_d  = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d   = BIT_LAST;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_d = BIT_LAST;
                    if (tx_bit == '1) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit + 1'b1;
                        tx_shift_d = tx_shift >> 1;
                        tx_line_d  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_cnt_d   = BIT_LAST;
                        tx_line_d  = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt - 1'b1;
                end
            end
            default: begin
                tx_line_d  = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta          <= 1'b1;
            rx_sync          <= 1'b1;
            rx_state         <= RX_IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_shift         <= '0;
            rx_overrun_out   <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            rx_meta          <= uart_rx_in;
            rx_sync          <= rx_meta;
            rx_state         <= rx_state_d;
            rx_cnt           <= rx_cnt_d;
            rx_bit           <= rx_bit_d;
            rx_shift         <= rx_shift_d;
            rx_overrun_out   <= rx_overrun_out | set_overrun;
            rx_frame_err_out <= rx_frame_err_out | set_frame_err;
        end
    end

    // Half-bit timing in START puts every later sample at a bit centre.
    always_comb begin
        rx_state_d    = rx_state;
        rx_cnt_d      = rx_cnt;
        rx_bit_d      = rx_bit;
        rx_shift_d    = rx_shift;
        rx_push       = 1'b0;
        set_overrun   = 1'b0;
        set_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_d   = HALF_LAST;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = BIT_LAST;
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_d = {rx_sync, rx_shift[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    if (rx_bit == '1) rx_state_d = RX_STOP;
                    else              rx_bit_d   = rx_bit + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    if (rx_sync) begin
                        rx_state_d = RX_IDLE;
                        if (rx_full) set_overrun = 1'b1;
                        else         rx_push     = 1'b1;
                    end else begin
                        set_frame_err = 1'b1;
                        rx_state_d    = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt - 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_serial_bridge.sv
// Directed/randomised bench for uart_serial_bridge: a line monitor decodes frames and queues model expected bytes.
module tb_uart_serial_bridge;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic       tx_wren_in = 1'b0;
    logic       tx_ready_out;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       rx_rden_in = 1'b0;
    logic       uart_rx_in;
    logic       uart_tx_out;
    logic       rx_overrun_out;
    logic       rx_frame_err_out;

    logic       loop_en = 1'b0;
    logic       tb_rx   = 1'b1;
    logic       mon_en  = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] tx_seen[$];
    int         tx_start[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rx_model[$];

    assign uart_rx_in = loop_en ? uart_tx_out : tb_rx;

    uart_serial_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .tx_data_in       (tx_data_in),
        .tx_wren_in       (tx_wren_in),
        .tx_ready_out     (tx_ready_out),
        .rx_data_out      (rx_data_out),
        .rx_valid_out     (rx_valid_out),
        .rx_rden_in       (rx_rden_in),
        .uart_rx_in       (uart_rx_in),
        .uart_tx_out      (uart_tx_out),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        tx_data_in = b;
        tx_wren_in = 1'b1;
        step(1);
        tx_wren_in = 1'b0;
    endtask

    task automatic wait_tx_frames(input int n, input int budget);
        int k = 0;
        while (tx_seen.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("tx_frame_count", tx_seen.size(), n);
    endtask

    task automatic check_tx_frames(input string tag);
        chk({tag, "_frames"}, tx_seen.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++)
            chk({tag, "_byte"}, (i < tx_seen.size()) ? tx_seen[i] : 8'hxx, exp_tx[i]);
        tx_seen.delete();
        tx_start.delete();
        exp_tx.delete();
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        tb_rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            tb_rx = b[i];
            step(CPB);
        end
        tb_rx = stop;
        step(CPB);
        tb_rx = 1'b1;
        step(CPB);
    endtask

    task automatic rx_pop_check(input logic [7:0] exp, input string tag);
        int k = 0;
        while (!rx_valid_out && k < 600) begin
            step(1);
            k++;
        end
        chk({tag, "_valid"}, rx_valid_out, 1);
        chk({tag, "_data"}, rx_data_out, exp);
        rx_rden_in = 1'b1;
        step(1);
        rx_rden_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_line"},   uart_tx_out, 1);
        chk({tag, "_tx_ready"},  tx_ready_out, 1);
        chk({tag, "_rx_valid"},  rx_valid_out, 0);
        chk({tag, "_rx_data"},   rx_data_out, 0);
        chk({tag, "_overrun"},   rx_overrun_out, 0);
        chk({tag, "_frame_err"}, rx_frame_err_out, 0);
    endtask

    // Decodes frames on uart_tx_out by sampling at bit centres.
    initial begin
        logic [7:0] b;
        int st;
        forever begin
            step(1);
            if (mon_en && reset && uart_tx_out === 1'b0) begin
                st = cyc;
                step(CPB / 2);
                chk("mon_start_bit", uart_tx_out, 0);
                for (int i = 0; i < 8; i++) begin
                    step(CPB);
                    b[i] = uart_tx_out;
                end
                step(CPB);
                chk("mon_stop_bit", uart_tx_out, 1);
                tx_seen.push_back(b);
                tx_start.push_back(st);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cyc;
        int rise_cyc;
        int cnt;
        int k;
        int lows;
        logic acc;
        logic dropped;
        logic [7:0] b;
        logic [7:0] pat [3];

        step(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        step(6);

        // Single byte: start bit one edge after the write, LSB-first data.
        wr_byte(8'hA5);
        wr_cyc = cyc;
        chk("tx_idle_at_write", uart_tx_out, 1);
        exp_tx.push_back(8'hA5);
        step(1);
        chk("tx_start_latency", uart_tx_out, 0);
        wait_tx_frames(1, 400);
        chk("tx_start_cycle", (tx_start.size() > 0) ? tx_start[0] : -1, wr_cyc + 1);
        check_tx_frames("tx_a5");
        step(20);

        // Back-to-back writes past full; model tracks FIFO occupancy.
        cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            chk("tx_ready_model", tx_ready_out, (cnt < DEPTH));
            acc = (cnt < DEPTH);
            b = 8'($urandom);
            tx_data_in = b;
            tx_wren_in = 1'b1;
            step(1);
            if (acc) exp_tx.push_back(b);
            cnt = cnt + int'(acc) - ((i == 1) ? 1 : 0);
        end
        tx_wren_in = 1'b0;
        chk("tx_ready_full", tx_ready_out, (cnt < DEPTH));
        k = 0;
        while (!tx_ready_out && k < 400) begin
            step(1);
            k++;
        end
        rise_cyc = cyc;
        wait_tx_frames(DEPTH + 1, 2000);
        chk("tx_ready_after_pop", rise_cyc, (tx_start.size() > 0) ? tx_start[0] + 10 * CPB : -1);
        for (int i = 1; i < tx_start.size(); i++)
            chk("tx_frame_spacing", tx_start[i] - tx_start[i-1], 10 * CPB);
        check_tx_frames("tx_burst");
        step(20);

        // Loopback of TX into RX.
        loop_en = 1'b1;
        chk("rx_empty_data", rx_data_out, 0);
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            wr_byte(pat[i]);
            exp_tx.push_back(pat[i]);
            rx_pop_check(pat[i], "rx_loop");
        end
        chk("rx_loop_drained", rx_valid_out, 0);
        chk("rx_loop_empty_data", rx_data_out, 0);
        wait_tx_frames(3, 400);
        check_tx_frames("tx_loop");
        step(20);
        loop_en = 1'b0;
        step(5);

        // Short low glitch is rejected.
        tb_rx = 1'b0;
        step(4);
        tb_rx = 1'b1;
        step(40);
        chk("glitch_no_push", rx_valid_out, 0);
        chk("glitch_no_ferr", rx_frame_err_out, 0);
        chk("glitch_no_ovr", rx_overrun_out, 0);

        // Bad stop bit, then a good frame.
        uart_send(8'h55, 1'b0);
        step(4);
        chk("ferr_no_push", rx_valid_out, 0);
        chk("ferr_flag", rx_frame_err_out, 1);
        chk("ferr_no_ovr", rx_overrun_out, 0);
        uart_send(8'h12, 1'b1);
        rx_pop_check(8'h12, "rx_after_ferr");
        chk("ferr_sticky", rx_frame_err_out, 1);

        // Overrun: RX FIFO keeps the first DEPTH bytes.
        dropped = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            uart_send(b, 1'b1);
            if (rx_model.size() < DEPTH) rx_model.push_back(b);
            else                         dropped = 1'b1;
            chk("rx_overrun_model", rx_overrun_out, dropped);
        end
        while (rx_model.size() > 0) begin
            b = rx_model.pop_front();
            rx_pop_check(b, "rx_fifo_order");
        end
        chk("rx_drained", rx_valid_out, 0);

        // Reset mid-frame with data in both directions.
        mon_en = 1'b0;
        uart_send(8'h77, 1'b1);
        chk("rx_held_before_reset", rx_valid_out, 1);
        wr_byte(8'h00);
        wr_byte(8'h00);
        step(40);
        chk("tx_mid_frame_low", uart_tx_out, 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        step(3);
        chk("reset_hold_line", uart_tx_out, 1);
        reset = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (uart_tx_out !== 1'b1) lows++;
        end
        chk("post_reset_line_idle", lows, 0);
        chk("post_reset_ready", tx_ready_out, 1);
        chk("post_reset_rx_empty", rx_valid_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
